// File: rtl/clkgen_init_seq.sv
// rtl/clkgen_init_seq.sv - power-up register-table sequencer for the I2C clock generator
module clkgen_init_seq #(
  parameter logic [6:0] I2C_ADDR      = 7'h60,
  parameter int         NUM_REGS      = 64,
  parameter int         STARTUP_DELAY = 10000,
  parameter int         MAX_RETRY     = 3,
  parameter int         TIMEOUT       = 4095
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        start,
  output logic [7:0]  tbl_addr,
  input  logic [15:0] tbl_data,
  output logic        i2c_cmd_valid,
  input  logic        i2c_cmd_ready,
  output logic [6:0]  i2c_cmd_dev,
  output logic [7:0]  i2c_cmd_reg,
  output logic [7:0]  i2c_cmd_data,
  input  logic        i2c_done,
  input  logic        i2c_nack,
  output logic        busy,
  output logic        done,
  output logic        error,
  output logic [7:0]  err_index,
  output logic        dsp_run
);

  localparam int              TW        = ($clog2(TIMEOUT + 1) > 12) ? $clog2(TIMEOUT + 1) : 12;
  localparam logic [31:0]     DLY_LAST  = 32'(STARTUP_DELAY - 1);
  localparam logic [TW-1:0]   TMO_LAST  = TW'(TIMEOUT - 1);
  localparam logic [7:0]      IDX_LAST  = 8'(NUM_REGS - 1);
  localparam logic [3:0]      RETRY_MAX = 4'(MAX_RETRY);

  typedef enum logic [2:0] {
    S_WAIT, S_FETCH, S_LATCH, S_ISSUE, S_ACK, S_DONE, S_FAIL
  } state_t;

  state_t        state, state_nx;
  logic [31:0]   dly_cnt;
  logic [TW-1:0] tmo_cnt;
  logic [7:0]    idx;
  logic [3:0]    retry;
  logic          xfer, ack_ok, ack_fail, last_entry, restart;
  logic          busy_nx, done_nx, error_nx, valid_nx;

  assign tbl_addr   = idx;
  assign xfer       = (state == S_ISSUE) && i2c_cmd_valid && i2c_cmd_ready;
  assign ack_ok     = i2c_done && !i2c_nack;
  // A done pulse on the timeout cycle is honoured, so the timeout only fires without one.
  assign ack_fail   = i2c_done ? i2c_nack : (tmo_cnt == TMO_LAST);
  assign last_entry = (idx == IDX_LAST);
  assign restart    = start && ((state == S_DONE) || (state == S_FAIL));

  always_ff @(posedge clock or posedge reset) begin
    if (reset) state <= S_WAIT;
    else       state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      S_WAIT:  if (dly_cnt == DLY_LAST) state_nx = S_FETCH;
      S_FETCH: state_nx = S_LATCH;
      S_LATCH: state_nx = (tbl_data[15:8] == 8'hFF) ? S_DONE : S_ISSUE;
      S_ISSUE: if (xfer) state_nx = S_ACK;
      S_ACK: begin
        if (ack_ok)        state_nx = last_entry ? S_DONE : S_FETCH;
        else if (ack_fail) state_nx = (retry == RETRY_MAX) ? S_FAIL : S_ISSUE;
      end
      S_DONE, S_FAIL: if (start) state_nx = S_FETCH;
      default: state_nx = S_WAIT;
    endcase
  end

  // Status outputs are decoded from the next state so they register alongside it.
  always_comb begin
    busy_nx  = 1'b0;
    done_nx  = 1'b0;
    error_nx = 1'b0;
    valid_nx = 1'b0;
    case (state_nx)
      S_WAIT, S_FETCH, S_LATCH, S_ACK: busy_nx = 1'b1;
      S_ISSUE: begin
        busy_nx  = 1'b1;
        valid_nx = 1'b1;
      end
      S_DONE:  done_nx  = 1'b1;
      S_FAIL:  error_nx = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      busy          <= 1'b0;
      done          <= 1'b0;
      error         <= 1'b0;
      dsp_run       <= 1'b0;
      i2c_cmd_valid <= 1'b0;
      i2c_cmd_dev   <= 7'd0;
      i2c_cmd_reg   <= 8'd0;
      i2c_cmd_data  <= 8'd0;
      err_index     <= 8'd0;
      dly_cnt       <= 32'd0;
      tmo_cnt       <= '0;
      idx           <= 8'd0;
      retry         <= 4'd0;
    end else begin
      busy          <= busy_nx;
      done          <= done_nx;
      error         <= error_nx;
      dsp_run       <= done_nx;
      i2c_cmd_valid <= valid_nx;

      if (state == S_WAIT) dly_cnt <= dly_cnt + 32'd1;

      if (state == S_LATCH) begin
        i2c_cmd_dev  <= I2C_ADDR;
        i2c_cmd_reg  <= tbl_data[15:8];
        i2c_cmd_data <= tbl_data[7:0];
      end

      if (xfer)                tmo_cnt <= '0;
      else if (state == S_ACK) tmo_cnt <= tmo_cnt + 1'b1;

      if (state == S_ACK) begin
        if (ack_ok) begin
          retry <= 4'd0;
          if (!last_entry) idx <= idx + 8'd1;
        end else if (ack_fail) begin
          if (retry == RETRY_MAX) err_index <= idx;
          else                    retry     <= retry + 4'd1;
        end
      end

      if (restart) begin
        idx   <= 8'd0;
        retry <= 4'd0;
      end
    end
  end

endmodule

// File: tb/tb_clkgen_init_seq.sv
// tb/tb_clkgen_init_seq.sv - self-checking bench for clkgen_init_seq
module tb_clkgen_init_seq;

  localparam int SD  = 4;
  localparam int NR  = 3;
  localparam int MR  = 3;
  localparam int TO  = 20;
  localparam int INF = 1 << 30;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic [7:0]  tbl_addr;
  logic [15:0] tbl_data = 16'h0;
  logic        i2c_cmd_valid;
  logic        i2c_cmd_ready = 1'b0;
  logic [6:0]  i2c_cmd_dev;
  logic [7:0]  i2c_cmd_reg;
  logic [7:0]  i2c_cmd_data;
  logic        i2c_done = 1'b0;
  logic        i2c_nack = 1'b0;
  logic        busy, done, error, dsp_run;
  logic [7:0]  err_index;

  clkgen_init_seq #(
    .I2C_ADDR(7'h60), .NUM_REGS(NR), .STARTUP_DELAY(SD), .MAX_RETRY(MR), .TIMEOUT(TO)
  ) dut (
    .clock(clock), .reset(reset), .start(start),
    .tbl_addr(tbl_addr), .tbl_data(tbl_data),
    .i2c_cmd_valid(i2c_cmd_valid), .i2c_cmd_ready(i2c_cmd_ready),
    .i2c_cmd_dev(i2c_cmd_dev), .i2c_cmd_reg(i2c_cmd_reg), .i2c_cmd_data(i2c_cmd_data),
    .i2c_done(i2c_done), .i2c_nack(i2c_nack),
    .busy(busy), .done(done), .error(error), .err_index(err_index), .dsp_run(dsp_run)
  );

  always #5 clock = ~clock;

  logic [15:0] rom [256];
  always @(posedge clock) tbl_data <= rom[tbl_addr];

  int cyc;
  always @(posedge clock or posedge reset) begin
    if (reset) cyc <= 0;
    else       cyc <= cyc + 1;
  end

  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Scenario knobs and model state
  int  plan_fail [256];
  bit  plan_to   [256];
  int  lat, rdy_delay;
  bit  req_start = 1'b0;
  int  cur_idx, attempts, done_at, err_at, exp_valid_cyc, exp_err_index;
  bit  in_flight, res_fail, res_to, prev_valid;
  int  res_edge, stray_edge, vh_cnt, first_rise, start_edge;
  int          xfer_idx [$];
  int          xfer_cyc [$];
  logic [22:0] xfer_fld [$];

  // The table entry at cur_idx is read by a FETCH entered at edge f.
  task automatic model_fetch(input int f);
    if (rom[cur_idx][15:8] == 8'hFF) done_at = f + 2;
    else                             exp_valid_cyc = f + 2;
  endtask

  task automatic model_resolve(input int e, input bit ok);
    if (ok) begin
      attempts = 0;
      if (cur_idx == NR - 1) done_at = e;
      else begin
        cur_idx++;
        model_fetch(e);
      end
    end else if (attempts == MR) begin
      err_at = e;
      exp_err_index = cur_idx;
    end else begin
      attempts++;
      exp_valid_cyc = e;
    end
  endtask

  task automatic model_init();
    cur_idx = 0; attempts = 0; done_at = INF; err_at = INF; exp_valid_cyc = INF;
    in_flight = 0; stray_edge = INF; res_edge = INF; prev_valid = 0; vh_cnt = 0;
    model_fetch(SD);
  endtask

  function automatic int count_idx(input int v);
    int c = 0;
    foreach (xfer_idx[i]) if (xfer_idx[i] == v) c++;
    return c;
  endfunction

  bit p_d, p_k, p_rdy, p_rise, p_st, ed, ee, eb;
  int n, e;

  // Engine model plus per-cycle comparison against the behavioural model.
  always @(negedge clock) begin
    n = cyc;
    if (reset) begin
      chk("reset_outputs", 64'({busy, done, error, dsp_run, i2c_cmd_valid, tbl_addr,
          i2c_cmd_dev, i2c_cmd_reg, i2c_cmd_data, err_index}), 64'd0);
      model_init();
      first_rise = -1;
      i2c_cmd_ready = 0; i2c_done = 0; i2c_nack = 0; start = 0;
    end else begin
      ed = (n >= done_at);
      ee = (n >= err_at);
      eb = (n >= 1) && !ed && !ee;
      chk("status_busy_done_error_run", 64'({busy, done, error, dsp_run}), 64'({eb, ed, ee, ed}));
      if (ee) chk("err_index", 64'(err_index), 64'(exp_err_index));
      p_rise = i2c_cmd_valid && !prev_valid;
      if (p_rise || n == exp_valid_cyc) chk("valid_rise_cycle", 64'(p_rise), 64'(n == exp_valid_cyc));
      if (p_rise && first_rise < 0) first_rise = n;
      if (i2c_cmd_valid)
        chk("cmd_fields", 64'({i2c_cmd_dev, i2c_cmd_reg, i2c_cmd_data}), 64'({7'h60, rom[cur_idx]}));
      prev_valid = i2c_cmd_valid;

      e = n + 1;
      p_d = 0; p_k = 0;
      if (in_flight && e == res_edge) begin
        if (!res_to) begin p_d = 1; p_k = res_fail; end
        model_resolve(e, !res_fail);
        in_flight = 0;
      end
      if (e == stray_edge) begin p_d = 1; p_k = 0; end
      p_rdy = i2c_cmd_valid && (vh_cnt >= rdy_delay);
      if (p_rdy) begin
        xfer_idx.push_back(cur_idx);
        xfer_cyc.push_back(e);
        xfer_fld.push_back({i2c_cmd_dev, i2c_cmd_reg, i2c_cmd_data});
        in_flight = 1;
        res_fail  = attempts < plan_fail[cur_idx];
        res_to    = res_fail && plan_to[cur_idx];
        res_edge  = res_to ? e + TO : e + lat;
        if (res_to) stray_edge = e + TO + 1;
      end
      vh_cnt = (i2c_cmd_valid && !p_rdy) ? vh_cnt + 1 : 0;

      p_st = 0;
      if (req_start) begin
        p_st = 1;
        req_start = 0;
        if (n >= done_at || n >= err_at) begin
          done_at = INF; err_at = INF; cur_idx = 0; attempts = 0;
          start_edge = e;
          model_fetch(e);
        end
      end
      i2c_cmd_ready = p_rdy; i2c_done = p_d; i2c_nack = p_k; start = p_st;
    end
  end

  task automatic clear_log();
    xfer_idx.delete(); xfer_cyc.delete(); xfer_fld.delete();
    first_rise = -1;
  endtask

  task automatic pulse_start();
    @(negedge clock); #1 req_start = 1;
    @(negedge clock);
    @(negedge clock);
  endtask

  task automatic wait_end(input int budget);
    int k = 0;
    while (!(done || error) && k < budget) begin
      @(negedge clock);
      k++;
    end
    if (k >= budget) chk("wait_bound", 64'd0, 64'd1);
    repeat (3) @(negedge clock);
  endtask

  logic [22:0] t1_exp [3];

  initial begin
    t1_exp = '{23'h600300, 23'h600F00, 23'h60B7C0};
    for (int i = 0; i < 256; i++) begin rom[i] = 16'h0; plan_fail[i] = 0; plan_to[i] = 0; end
    rom[0] = 16'h0300; rom[1] = 16'h0F00; rom[2] = 16'hB7C0;
    lat = 2; rdy_delay = 0;

    // Basic walk after reset
    repeat (3) @(negedge clock);
    #2 reset = 0;
    clear_log();
    wait_end(500);
    chk("t1_first_valid", 64'(first_rise), 64'd6);
    chk("t1_count", 64'(xfer_idx.size()), 64'd3);
    for (int i = 0; i < 3; i++)
      if (i < xfer_fld.size()) chk("t1_xfer_fields", 64'(xfer_fld[i]), 64'(t1_exp[i]));
    chk("t1_final", 64'({done, dsp_run, error}), 64'(3'b110));

    // Entry 1 NACKed twice, engine slow to accept
    plan_fail[1] = 2; rdy_delay = 2; lat = 1;
    clear_log(); pulse_start(); wait_end(500);
    chk("t2_entry1_attempts", 64'(count_idx(1)), 64'd3);
    foreach (xfer_idx[i]) if (xfer_idx[i] == 1) chk("t2_retry_fields", 64'(xfer_fld[i]), 64'h600F00);
    chk("t2_final", 64'({done, error}), 64'(2'b10));

    // Entry 2 always NACKed, then a clean restart
    plan_fail[1] = 0; plan_fail[2] = 99; rdy_delay = 0; lat = 3;
    clear_log(); pulse_start(); wait_end(500);
    chk("t3_final", 64'({error, done, dsp_run}), 64'(3'b100));
    chk("t3_err_index", 64'(err_index), 64'd2);
    chk("t3_entry2_attempts", 64'(count_idx(2)), 64'd4);
    plan_fail[2] = 0;
    clear_log(); pulse_start(); wait_end(500);
    chk("t3_restart_no_delay", 64'(first_rise), 64'(start_edge + 2));
    chk("t3_restart_count", 64'(xfer_idx.size()), 64'd3);
    chk("t3_restart_done", 64'({done, error}), 64'(2'b10));

    // Done arriving on the timeout cycle wins
    lat = TO;
    clear_log(); pulse_start(); wait_end(800);
    chk("t5_count", 64'(xfer_idx.size()), 64'd3);
    chk("t5_done", 64'({done, error}), 64'(2'b10));

    // End-of-table marker at entry 1
    rom[1] = 16'hFF00; lat = 2;
    clear_log(); pulse_start(); wait_end(500);
    chk("t6_count", 64'(xfer_idx.size()), 64'd1);
    chk("t6_done", 64'({done, dsp_run}), 64'(2'b11));
    rom[1] = 16'h0F00;

    // Timeouts: one on entry 0, every attempt on entry 1
    plan_fail[0] = 1; plan_to[0] = 1; plan_fail[1] = 99; plan_to[1] = 1;
    clear_log(); pulse_start(); wait_end(1000);
    chk("t4_final", 64'({error, done}), 64'(2'b10));
    chk("t4_err_index", 64'(err_index), 64'd1);
    chk("t4_count", 64'(xfer_idx.size()), 64'd6);
    if (xfer_cyc.size() >= 2) chk("t4_retry_spacing", 64'(xfer_cyc[1] - xfer_cyc[0]), 64'd21);

    // Reset in the middle of an ACK wait; start during WAIT is ignored
    plan_fail[0] = 0; plan_to[0] = 0; plan_fail[1] = 0; plan_to[1] = 0; lat = 10;
    clear_log(); pulse_start();
    for (int k = 0; k < 200 && xfer_idx.size() < 1; k++) @(negedge clock);
    repeat (3) @(negedge clock);
    #3 reset = 1;
    #1 chk("t7_async_reset", 64'({busy, done, error, dsp_run, i2c_cmd_valid, err_index}), 64'd0);
    @(negedge clock); #2 reset = 0;
    clear_log();
    @(negedge clock); #1 req_start = 1;
    wait_end(500);
    chk("t7_first_valid", 64'(first_rise), 64'd6);
    chk("t7_count", 64'(xfer_idx.size()), 64'd3);
    chk("t7_done", 64'({done, dsp_run, error}), 64'(3'b110));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
